// File: rtl/some_logic_pkg.sv
// Shared definitions for the bitwise logic unit: op encoding, the Boolean
// evaluation function and a parity helper, usable by both RTL and scoreboards.
package some_logic_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_ANDN = 3'd6,
    OP_PASS = 3'd7
  } logic_op_e;

  // Evaluated at full width; callers keep the low WIDTH bits.
  function automatic logic [MAX_W-1:0] logic_eval(input logic_op_e op,
                                                  input logic [MAX_W-1:0] a,
                                                  input logic [MAX_W-1:0] b);
    logic [MAX_W-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_ANDN: r = a & ~b;
      OP_PASS: r = a;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic logic parity_of(input logic [MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/some_logic_if.sv
// Operand/result bundle for some_logic_core; the producer side uses master,
// the logic unit uses slave.
interface some_logic_if #(
  parameter int WIDTH = 1,
  localparam int CNT_W = $clog2(WIDTH + 1)
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             in_valid;
  logic [WIDTH-1:0] c;
  logic             out_valid;
  logic             zero;
  logic             parity;
  logic [CNT_W-1:0] ones;

  modport master (
    output a, b, op, in_valid,
    input  c, out_valid, zero, parity, ones
  );

  modport slave (
    input  a, b, op, in_valid,
    output c, out_valid, zero, parity, ones
  );

endinterface

// File: rtl/some_logic_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module some_logic_popcount #(
  parameter int WIDTH = 1,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [CNT_W-1:0] cnt
);

  // Sum of set bits; accumulator width already covers the all-ones case.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CNT_W'(vec[i]);
    end
  end

endmodule

// File: rtl/some_logic_core.sv
// Registered two-operand bitwise logic unit with zero/parity/ones flags.
// Results and flags load together on in_valid and otherwise hold.
module some_logic_core
  import some_logic_pkg::*;
#(
  parameter int WIDTH = 1,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic         clk,
  input logic         rst_n,
  some_logic_if.slave bus
);

  logic [MAX_W-1:0] eval_s;
  logic [WIDTH-1:0] result_s;
  logic [CNT_W-1:0] ones_s;

  logic [WIDTH-1:0] c_r;
  logic             valid_r;
  logic             zero_r;
  logic             parity_r;
  logic [CNT_W-1:0] ones_r;

  // Op mux: full-width evaluation, truncated to the operand width.
  always_comb begin
    eval_s   = logic_eval(logic_op_e'(bus.op), MAX_W'(bus.a), MAX_W'(bus.b));
    result_s = eval_s[WIDTH-1:0];
  end

  some_logic_popcount #(.WIDTH(WIDTH)) u_popcount (
    .vec (result_s),
    .cnt (ones_s)
  );

  // Flags derive from the incoming result so they always match the loaded c.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_r      <= '0;
      valid_r  <= 1'b0;
      zero_r   <= 1'b1;
      parity_r <= 1'b0;
      ones_r   <= '0;
    end else begin
      valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        c_r      <= result_s;
        zero_r   <= ~|result_s;
        parity_r <= parity_of(MAX_W'(result_s));
        ones_r   <= ones_s;
      end else begin
        c_r      <= c_r;
        zero_r   <= zero_r;
        parity_r <= parity_r;
        ones_r   <= ones_r;
      end
    end
  end

  assign bus.c         = c_r;
  assign bus.out_valid = valid_r;
  assign bus.zero      = zero_r;
  assign bus.parity    = parity_r;
  assign bus.ones      = ones_r;

endmodule

// File: tb/tb_some_logic_core.sv
// Self-checking bench for some_logic_core: directed cases on WIDTH=1 and
// WIDTH=8 instances, then randomized traffic against a truth-table model.
module tb_some_logic_core;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  some_logic_if #(.WIDTH(1)) bus1();
  some_logic_if #(.WIDTH(8)) bus8();

  some_logic_core #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  some_logic_core #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected state of the WIDTH=8 instance.
  logic [7:0] exp_c;
  logic       exp_v;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-bit truth table indexed by {a_bit, b_bit}.
  function automatic logic [7:0] ref_eval(input int op, input logic [7:0] a, input logic [7:0] b);
    logic [3:0] tt;
    logic [7:0] r;
    case (op)
      0: tt = 4'b1000;
      1: tt = 4'b1110;
      2: tt = 4'b0110;
      3: tt = 4'b0111;
      4: tt = 4'b0001;
      5: tt = 4'b1001;
      6: tt = 4'b0100;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < 8; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  task automatic cycle8(input logic [7:0] a, input logic [7:0] b, input int op, input logic v);
    bus8.a = a;
    bus8.b = b;
    bus8.op = 3'(op);
    bus8.in_valid = v;
    if (v) exp_c = ref_eval(op, a, b);
    exp_v = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag);
    check_eq({tag, ".valid"}, 64'(bus8.out_valid), 64'(exp_v));
    check_eq({tag, ".c"}, 64'(bus8.c), 64'(exp_c));
    check_eq({tag, ".zero"}, 64'(bus8.zero), 64'(exp_c == 8'h00));
    check_eq({tag, ".parity"}, 64'(bus8.parity), 64'(^exp_c));
    check_eq({tag, ".ones"}, 64'(bus8.ones), 64'($countones(exp_c)));
  endtask

  initial begin
    logic [7:0] sweep_c [8];
    logic [3:0] sweep_ones [8];
    logic [3:0] pairs;
    logic [3:0] w1_c;
    checks = 0;
    errors = 0;
    exp_c = 8'h00;
    exp_v = 1'b0;
    sweep_c = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hC0, 8'hF0};
    sweep_ones = '{4'd2, 4'd6, 4'd4, 4'd6, 4'd2, 4'd4, 4'd2, 4'd4};

    rst_n = 1'b0;
    bus1.a = 1'b0; bus1.b = 1'b0; bus1.op = 3'd0; bus1.in_valid = 1'b0;
    bus8.a = 8'h00; bus8.b = 8'h00; bus8.op = 3'd0; bus8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check8("reset8");
    check_eq("reset1.c", 64'(bus1.c), 64'd0);
    check_eq("reset1.valid", 64'(bus1.out_valid), 64'd0);
    check_eq("reset1.zero", 64'(bus1.zero), 64'd1);
    check_eq("reset1.ones", 64'(bus1.ones), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 AND over 00,10,01,11
    pairs = 4'b0000;
    w1_c = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      bus1.a = (i == 1 || i == 3) ? 1'b1 : 1'b0;
      bus1.b = (i >= 2) ? 1'b1 : 1'b0;
      bus1.op = 3'd0;
      bus1.in_valid = 1'b1;
      @(posedge clk);
      #1;
      check_eq($sformatf("w1_and%0d.c", i), 64'(bus1.c), 64'(w1_c[i]));
      check_eq($sformatf("w1_and%0d.zero", i), 64'(bus1.zero), 64'(!w1_c[i]));
      check_eq($sformatf("w1_and%0d.valid", i), 64'(bus1.out_valid), 64'd1);
    end
    bus1.in_valid = 1'b0;

    // Op sweep with spec constants
    for (int op = 0; op < 8; op++) begin
      cycle8(8'hF0, 8'h3C, op, 1'b1);
      check_eq($sformatf("sweep%0d.c", op), 64'(bus8.c), 64'(sweep_c[op]));
      check_eq($sformatf("sweep%0d.ones", op), 64'(bus8.ones), 64'(sweep_ones[op]));
      check_eq($sformatf("sweep%0d.parity", op), 64'(bus8.parity), 64'd0);
      check8($sformatf("sweep%0d", op));
    end

    // Hold after in_valid drops
    cycle8(8'hA5, 8'hFF, 2, 1'b1);
    check_eq("hold.first_c", 64'(bus8.c), 64'h5A);
    check_eq("hold.first_parity", 64'(bus8.parity), 64'd0);
    check_eq("hold.first_valid", 64'(bus8.out_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      cycle8(8'h12, 8'h34, 0, 1'b0);
      check_eq($sformatf("hold%0d.valid", i), 64'(bus8.out_valid), 64'd0);
      check_eq($sformatf("hold%0d.c", i), 64'(bus8.c), 64'h5A);
    end

    // All-zero and all-one results
    cycle8(8'hFF, 8'hFF, 4, 1'b1);
    check_eq("nor.c", 64'(bus8.c), 64'h00);
    check_eq("nor.zero", 64'(bus8.zero), 64'd1);
    check_eq("nor.ones", 64'(bus8.ones), 64'd0);
    cycle8(8'h00, 8'h00, 3, 1'b1);
    check_eq("nand.c", 64'(bus8.c), 64'hFF);
    check_eq("nand.ones", 64'(bus8.ones), 64'd8);
    check_eq("nand.parity", 64'(bus8.parity), 64'd0);
    check_eq("nand.zero", 64'(bus8.zero), 64'd0);

    // Mid-stream asynchronous reset
    cycle8(8'h0F, 8'h00, 7, 1'b1);
    check8("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    exp_c = 8'h00;
    exp_v = 1'b0;
    check8("async_rst");
    bus8.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle8(8'h3C, 8'h0F, 0, 1'b1);
    check_eq("post_rst.c", 64'(bus8.c), 64'h0C);
    check_eq("post_rst.valid", 64'(bus8.out_valid), 64'd1);

    // Randomized traffic; operands are don't-care while in_valid is low
    for (int n = 0; n < 1000; n++) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      cycle8(v ? 8'($urandom) : 8'hxx, v ? 8'($urandom) : 8'hxx, $urandom_range(0, 7), v);
      check8($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
